// File: rtl/power_map_sweep.sv
// power_map_sweep: drives all 64 operands through an external 6-bit
// combinational stage and captures the 64 results.
// It reports whether the captured map is a permutation. For the latched
// input difference it also reports the largest DDT row count and the
// lowest output difference that reaches it.
module power_map_sweep (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] delta,
   output logic [5:0] sbox_x,
   input  logic [5:0] sbox_y,
   output logic       busy,
   output logic       done,
   output logic       is_perm,
   output logic [6:0] diff_max,
   output logic [5:0] diff_arg
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_DIFF, S_SCAN, S_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [5:0]  r_idx;
   logic [5:0]  r_delta;
   logic [63:0] r_seen;
   logic [5:0]  r_table [64];
   logic [6:0]  r_count [64];
   logic [6:0]  r_max;
   logic [5:0]  r_arg;
   // The last SCAN compare lands on the idx=63 edge. This flag spends one
   // more SCAN cycle so the results are taken from the settled running values.
   logic        r_scan_end;

   logic        w_accept;
   logic        w_last;
   logic [5:0]  w_d;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_idx == 6'd63);
   assign w_d      = r_table[r_idx] ^ r_table[r_idx ^ r_delta];

   // next-state and state-decoded outputs
   always_comb begin
      w_state_nxt = r_state;
      sbox_x      = 6'd0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = S_FILL;
         S_FILL: begin
            sbox_x = r_idx;
            busy   = 1'b1;
            if (w_last) w_state_nxt = S_DIFF;
         end
         S_DIFF: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_SCAN;
         end
         S_SCAN: begin
            busy = 1'b1;
            if (r_scan_end) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state register, index counter, seen vector, running max and results
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= 6'd0;
         r_delta    <= 6'd0;
         r_seen     <= 64'd0;
         r_max      <= 7'd0;
         r_arg      <= 6'd0;
         r_scan_end <= 1'b0;
         is_perm    <= 1'b0;
         diff_max   <= 7'd0;
         diff_arg   <= 6'd0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: if (start) begin
               r_delta    <= delta;
               r_idx      <= 6'd0;
               r_seen     <= 64'd0;
               r_max      <= 7'd0;
               r_arg      <= 6'd0;
               r_scan_end <= 1'b0;
               is_perm    <= 1'b0;
               diff_max   <= 7'd0;
               diff_arg   <= 6'd0;
            end
            S_FILL: begin
               r_seen[sbox_y] <= 1'b1;
               r_idx          <= r_idx + 6'd1;
            end
            S_DIFF: r_idx <= r_idx + 6'd1;
            S_SCAN: begin
               if (!r_scan_end) begin
                  // strict compare keeps the lowest index on ties
                  if (r_count[r_idx] > r_max) begin
                     r_max <= r_count[r_idx];
                     r_arg <= r_idx;
                  end
                  r_idx <= r_idx + 6'd1;
                  if (w_last) r_scan_end <= 1'b1;
               end else begin
                  is_perm    <= &r_seen;
                  diff_max   <= r_max;
                  diff_arg   <= r_arg;
                  r_scan_end <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // captured stage outputs; contents are only read after a full FILL
   always_ff @(posedge clk) begin
      if (r_state == S_FILL) r_table[r_idx] <= sbox_y;
   end

   // DDT row counters, cleared on reset and on every accepted start
   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         for (int i = 0; i < 64; i++) r_count[i] <= 7'd0;
      end else if (r_state == S_DIFF) begin
         r_count[w_d] <= r_count[w_d] + 7'd1;
      end
   end

endmodule
